// File: rtl/posit_mac_seq.sv
// posit_mac_seq: job sequencer that streams K weight/activation pairs per output
// from two synchronous-read buffers into the posit MAC and publishes each result.
module posit_mac_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned K     = 9,
   parameter int unsigned AW    = 10,
   parameter int unsigned NW    = 8,
   parameter int unsigned TMO   = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [AW-1:0]    w_base_i,
   input  logic [AW-1:0]    d_base_i,
   input  logic [NW-1:0]    n_out_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             w_re_o,
   output logic [AW-1:0]    w_addr_o,
   input  logic [WIDTH-1:0] w_rdata_i,
   output logic             d_re_o,
   output logic [AW-1:0]    d_addr_o,
   input  logic [WIDTH-1:0] d_rdata_i,
   output logic             mac_vld_o,
   output logic [WIDTH-1:0] mac_win_o,
   output logic [WIDTH-1:0] mac_din_o,
   input  logic [WIDTH-1:0] mac_acc_i,
   input  logic             mac_vld_i,
   output logic             res_vld_o,
   output logic [WIDTH-1:0] res_data_o,
   output logic [NW-1:0]    res_idx_o
);

   localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned TW = $clog2(TMO + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic [NW-1:0]   n;
   logic [NW-1:0]   n_last;
   logic [AW-1:0]   w_base;
   logic [TW-1:0]   tmo_cnt;
   logic            abort_act;
   logic            stray_vld;

   assign abort_act = abort_i && (state != S_IDLE);
   assign stray_vld = mac_vld_i && (state != S_WAIT) && !abort_act;

   // Read data reaches the MAC one cycle after the read; zero it outside valid beats.
   assign mac_win_o = mac_vld_o ? w_rdata_i : '0;
   assign mac_din_o = mac_vld_o ? d_rdata_i : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         k          <= '0;
         n          <= '0;
         n_last     <= '0;
         w_base     <= '0;
         tmo_cnt    <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         w_re_o     <= 1'b0;
         w_addr_o   <= '0;
         d_re_o     <= 1'b0;
         d_addr_o   <= '0;
         mac_vld_o  <= 1'b0;
         res_vld_o  <= 1'b0;
         res_data_o <= '0;
         res_idx_o  <= '0;
      end else begin
         done_o    <= 1'b0;
         res_vld_o <= 1'b0;
         mac_vld_o <= w_re_o && !abort_act;
         if (abort_act) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            w_re_o <= 1'b0;
            d_re_o <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_i) begin
                     err_o <= 1'b0;
                     if (n_out_i != '0) begin
                        state    <= S_ISSUE;
                        busy_o   <= 1'b1;
                        k        <= '0;
                        n        <= '0;
                        n_last   <= n_out_i - 1'b1;
                        w_base   <= w_base_i;
                        w_re_o   <= 1'b1;
                        d_re_o   <= 1'b1;
                        w_addr_o <= w_base_i;
                        d_addr_o <= d_base_i;
                     end else begin
                        done_o <= 1'b1;
                     end
                  end
               end
               S_ISSUE: begin
                  if (k == KW'(K - 1)) begin
                     state   <= S_WAIT;
                     tmo_cnt <= '0;
                     w_re_o  <= 1'b0;
                     d_re_o  <= 1'b0;
                  end else begin
                     k        <= k + 1'b1;
                     w_addr_o <= w_addr_o + 1'b1;
                     d_addr_o <= d_addr_o + 1'b1;
                  end
               end
               S_WAIT: begin
                  if (mac_vld_i) begin
                     res_vld_o  <= 1'b1;
                     res_data_o <= mac_acc_i;
                     res_idx_o  <= n;
                     if (n == n_last) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                     end else begin
                        // Activations are contiguous across outputs; weights restart at base.
                        state    <= S_ISSUE;
                        n        <= n + 1'b1;
                        k        <= '0;
                        w_re_o   <= 1'b1;
                        d_re_o   <= 1'b1;
                        w_addr_o <= w_base;
                        d_addr_o <= d_addr_o + 1'b1;
                     end
                  end else if (tmo_cnt == TW'(TMO - 1)) begin
                     state  <= S_IDLE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     err_o  <= 1'b1;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
         if (stray_vld) err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_posit_mac_seq.sv
// Testbench for posit_mac_seq: random buffer contents, a behavioural MAC and
// an address/result reference model derived from the job description.
module tb_posit_mac_seq;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned K     = 9;
   localparam int unsigned AW    = 10;
   localparam int unsigned NW    = 8;
   localparam int unsigned TMO   = 64;
   localparam int unsigned DEPTH = 1 << AW;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic             abort_i = 1'b0;
   logic [AW-1:0]    w_base_i = '0;
   logic [AW-1:0]    d_base_i = '0;
   logic [NW-1:0]    n_out_i = '0;
   logic             busy_o, done_o, err_o;
   logic             w_re_o, d_re_o;
   logic [AW-1:0]    w_addr_o, d_addr_o;
   logic [WIDTH-1:0] w_rdata_i = '0;
   logic [WIDTH-1:0] d_rdata_i = '0;
   logic             mac_vld_o;
   logic [WIDTH-1:0] mac_win_o, mac_din_o;
   logic [WIDTH-1:0] mac_acc_i = '0;
   logic             mac_vld_i = 1'b0;
   logic             res_vld_o;
   logic [WIDTH-1:0] res_data_o;
   logic [NW-1:0]    res_idx_o;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [WIDTH-1:0] wmem [DEPTH];
   logic [WIDTH-1:0] dmem [DEPTH];

   // MAC model controls
   int               mac_lat = 12;
   bit               mac_silent = 1'b0;
   bit               mac_const_en = 1'b0;
   logic [WIDTH-1:0] mac_const = '0;

   // Monitor records
   logic [AW-1:0]    w_addr_q [$];
   int               w_cyc_q  [$];
   logic [AW-1:0]    d_addr_q [$];
   logic [2*WIDTH-1:0] pair_q [$];
   int               mac_cyc_q [$];
   logic [NW+WIDTH-1:0] res_q [$];
   int               res_cyc_q [$];
   int               mi_cyc_q [$];
   int               done_cnt = 0;
   int               done_cyc_last = -1;
   logic             done_busy = 1'b0;

   posit_mac_seq #(.WIDTH(WIDTH), .K(K), .AW(AW), .NW(NW), .TMO(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .w_base_i(w_base_i), .d_base_i(d_base_i), .n_out_i(n_out_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .w_re_o(w_re_o), .w_addr_o(w_addr_o), .w_rdata_i(w_rdata_i),
      .d_re_o(d_re_o), .d_addr_o(d_addr_o), .d_rdata_i(d_rdata_i),
      .mac_vld_o(mac_vld_o), .mac_win_o(mac_win_o), .mac_din_o(mac_din_o),
      .mac_acc_i(mac_acc_i), .mac_vld_i(mac_vld_i),
      .res_vld_o(res_vld_o), .res_data_o(res_data_o), .res_idx_o(res_idx_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Synchronous-read buffers
   always @(posedge clk_i) begin
      if (w_re_o) w_rdata_i <= wmem[w_addr_o];
      if (d_re_o) d_rdata_i <= dmem[d_addr_o];
   end

   always @(posedge clk_i) if (mac_vld_i) mi_cyc_q.push_back(cyc);

   always @(negedge clk_i) begin
      if (w_re_o) begin w_addr_q.push_back(w_addr_o); w_cyc_q.push_back(cyc); end
      if (d_re_o) d_addr_q.push_back(d_addr_o);
      if (mac_vld_o) begin pair_q.push_back({mac_win_o, mac_din_o}); mac_cyc_q.push_back(cyc); end
      if (res_vld_o) begin res_q.push_back({res_idx_o, res_data_o}); res_cyc_q.push_back(cyc); end
      if (done_o) begin done_cnt++; done_cyc_last = cyc; done_busy = busy_o; end
   end

   function automatic logic [WIDTH-1:0] mac_step(input logic [WIDTH-1:0] acc, input int k,
                                                 input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] x;
      x = w ^ d;
      return WIDTH'(int'(acc) + int'(x) * (k + 1));
   endfunction

   // Behavioural MAC: accumulates K valid beats, answers after mac_lat idle cycles
   int               m_cnt = 0;
   int               m_wait = -1;
   logic [WIDTH-1:0] m_acc = '0;
   logic [WIDTH-1:0] m_res = '0;
   always @(negedge clk_i) begin
      mac_vld_i = 1'b0;
      if (rst_i || !busy_o) begin
         m_cnt = 0; m_acc = '0; m_wait = -1;
      end else if (mac_vld_o) begin
         m_acc = mac_step(m_acc, m_cnt, mac_win_o, mac_din_o);
         m_cnt++;
         if (m_cnt == K) begin m_res = m_acc; m_acc = '0; m_cnt = 0; m_wait = mac_lat; end
      end else if (m_wait > 0) begin
         m_wait--;
      end else if (m_wait == 0) begin
         m_wait = -1;
         if (!mac_silent) begin
            mac_vld_i = 1'b1;
            mac_acc_i = mac_const_en ? mac_const : m_res;
         end
      end
   end

   function automatic logic [AW-1:0] w_exp(input logic [AW-1:0] wb, input int k);
      return AW'((int'(wb) + k) % DEPTH);
   endfunction

   function automatic logic [AW-1:0] d_exp(input logic [AW-1:0] db, input int j, input int k);
      return AW'((int'(db) + j * K + k) % DEPTH);
   endfunction

   function automatic logic [WIDTH-1:0] exp_res(input logic [AW-1:0] wb, input logic [AW-1:0] db, input int j);
      logic [WIDTH-1:0] acc;
      acc = '0;
      for (int k = 0; k < K; k++) acc = mac_step(acc, k, wmem[w_exp(wb, k)], dmem[d_exp(db, j, k)]);
      return acc;
   endfunction

   task automatic start_job(input logic [AW-1:0] wb, input logic [AW-1:0] db,
                            input logic [NW-1:0] n, output int t);
      @(posedge clk_i); #1;
      start_i = 1'b1; w_base_i = wb; d_base_i = db; n_out_i = n; t = cyc;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk_i);
         if (done_o) seen = 1'b1;
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      tests++;
      if ({busy_o, done_o, err_o, w_re_o, d_re_o, mac_vld_o, res_vld_o} !== 7'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b, expected 0", {busy_o, done_o, err_o, w_re_o, d_re_o, mac_vld_o, res_vld_o});
      end
      tests++;
      if ({w_addr_o, d_addr_o, res_data_o, res_idx_o, mac_win_o, mac_din_o} !== '0) begin
         fails++;
         $display("FAIL reset_data: got %h, expected 0", {w_addr_o, d_addr_o, res_data_o, res_idx_o, mac_win_o, mac_din_o});
      end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      tests++;
      if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b, expected 0", busy_o); end
   endtask

   task automatic test_single();
      int t, w0, d0, p0, r0, dn0;
      bit seen;
      logic [AW-1:0] wb, db;
      wb = 10'h010; db = 10'h100;
      mac_silent = 1'b0; mac_const_en = 1'b1; mac_const = 8'h40; mac_lat = 12;
      w0 = w_addr_q.size(); d0 = d_addr_q.size(); p0 = pair_q.size(); r0 = res_q.size(); dn0 = done_cnt;
      start_job(wb, db, 8'd1, t);
      wait_done(200, seen);
      tests++;
      if (!seen) begin fails++; $display("FAIL single_done_seen: got 0, expected 1"); end
      tests++;
      if (w_addr_q.size() - w0 != K || d_addr_q.size() - d0 != K || pair_q.size() - p0 != K) begin
         fails++;
         $display("FAIL single_counts: got w=%0d d=%0d mac=%0d, expected %0d each",
                  w_addr_q.size() - w0, d_addr_q.size() - d0, pair_q.size() - p0, K);
      end else begin
         for (int k = 0; k < K; k++) begin
            tests++;
            if (w_addr_q[w0+k] !== AW'(10'h010 + k) || d_addr_q[d0+k] !== AW'(10'h100 + k)) begin
               fails++;
               $display("FAIL single_addr[%0d]: got w=%h d=%h, expected w=%h d=%h", k,
                        w_addr_q[w0+k], d_addr_q[d0+k], AW'(10'h010 + k), AW'(10'h100 + k));
            end
            tests++;
            if (w_cyc_q[w0+k] != t + 1 + k || mac_cyc_q[p0+k] != t + 2 + k) begin
               fails++;
               $display("FAIL single_timing[%0d]: got re@%0d vld@%0d, expected re@%0d vld@%0d", k,
                        w_cyc_q[w0+k], mac_cyc_q[p0+k], t + 1 + k, t + 2 + k);
            end
            tests++;
            if (pair_q[p0+k] !== {wmem[w_exp(wb, k)], dmem[d_exp(db, 0, k)]}) begin
               fails++;
               $display("FAIL single_pair[%0d]: got %h, expected %h", k, pair_q[p0+k],
                        {wmem[w_exp(wb, k)], dmem[d_exp(db, 0, k)]});
            end
         end
      end
      tests++;
      if (res_q.size() - r0 != 1) begin
         fails++; $display("FAIL single_res_count: got %0d, expected 1", res_q.size() - r0);
      end else begin
         tests++;
         if (res_q[r0] !== {8'd0, 8'h40}) begin
            fails++; $display("FAIL single_res: got %h, expected %h", res_q[r0], {8'd0, 8'h40});
         end
         tests++;
         if (res_cyc_q[r0] != done_cyc_last || done_busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done_with_res: got res@%0d done@%0d busy=%b, expected equal cycles busy=0",
                     res_cyc_q[r0], done_cyc_last, done_busy);
         end
         tests++;
         if (mi_cyc_q.size() == 0 || res_cyc_q[r0] != mi_cyc_q[mi_cyc_q.size()-1] + 1) begin
            fails++; $display("FAIL single_res_latency: got res@%0d, expected one cycle after mac_vld_i", res_cyc_q[r0]);
         end
      end
      tests++;
      if (done_cnt - dn0 != 1) begin fails++; $display("FAIL single_done_count: got %0d, expected 1", done_cnt - dn0); end
   endtask

   task automatic test_multi_wrap();
      int t, w0, d0, p0, r0, dn0;
      bit seen;
      logic [AW-1:0] wb, db, first1;
      wb = AW'($urandom_range(0, DEPTH - 1)); db = 10'h3FA; first1 = 10'h003;
      mac_silent = 1'b0; mac_const_en = 1'b0; mac_lat = $urandom_range(0, 12);
      w0 = w_addr_q.size(); d0 = d_addr_q.size(); p0 = pair_q.size(); r0 = res_q.size(); dn0 = done_cnt;
      start_job(wb, db, 8'd3, t);
      wait_done(300, seen);
      tests++;
      if (!seen) begin fails++; $display("FAIL multi_done_seen: got 0, expected 1"); end
      tests++;
      if (d_addr_q.size() - d0 != 3 * K || w_addr_q.size() - w0 != 3 * K || pair_q.size() - p0 != 3 * K) begin
         fails++;
         $display("FAIL multi_counts: got w=%0d d=%0d mac=%0d, expected %0d each",
                  w_addr_q.size() - w0, d_addr_q.size() - d0, pair_q.size() - p0, 3 * K);
      end else begin
         tests++;
         if (d_addr_q[d0+K] !== first1) begin
            fails++; $display("FAIL multi_wrap_first: got %h, expected %h", d_addr_q[d0+K], first1);
         end
         for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < K; k++) begin
               tests++;
               if (d_addr_q[d0+j*K+k] !== d_exp(db, j, k) || w_addr_q[w0+j*K+k] !== w_exp(wb, k) ||
                   pair_q[p0+j*K+k] !== {wmem[w_exp(wb, k)], dmem[d_exp(db, j, k)]}) begin
                  fails++;
                  $display("FAIL multi_read[%0d][%0d]: got w=%h d=%h pair=%h, expected w=%h d=%h pair=%h", j, k,
                           w_addr_q[w0+j*K+k], d_addr_q[d0+j*K+k], pair_q[p0+j*K+k],
                           w_exp(wb, k), d_exp(db, j, k), {wmem[w_exp(wb, k)], dmem[d_exp(db, j, k)]});
               end
            end
         end
      end
      tests++;
      if (res_q.size() - r0 != 3) begin
         fails++; $display("FAIL multi_res_count: got %0d, expected 3", res_q.size() - r0);
      end else begin
         for (int j = 0; j < 3; j++) begin
            tests++;
            if (res_q[r0+j] !== {NW'(j), exp_res(wb, db, j)}) begin
               fails++; $display("FAIL multi_res[%0d]: got %h, expected %h", j, res_q[r0+j], {NW'(j), exp_res(wb, db, j)});
            end
         end
         tests++;
         if (w_cyc_q.size() - w0 == 3 * K && (w_cyc_q[w0+K] != res_cyc_q[r0] || w_cyc_q[w0+2*K] != res_cyc_q[r0+1])) begin
            fails++; $display("FAIL multi_next_issue: got %0d/%0d, expected %0d/%0d",
                              w_cyc_q[w0+K], w_cyc_q[w0+2*K], res_cyc_q[r0], res_cyc_q[r0+1]);
         end
      end
      tests++;
      if (done_cnt - dn0 != 1) begin fails++; $display("FAIL multi_done_count: got %0d, expected 1", done_cnt - dn0); end
   endtask

   task automatic test_timeout();
      int t, t2, w0, r0, p0;
      bit seen;
      mac_silent = 1'b1;
      r0 = res_q.size(); p0 = pair_q.size();
      start_job(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)), 8'd1, t);
      repeat (K + 3) @(posedge clk_i);
      #1;
      tests++;
      if (mac_win_o !== '0 || mac_din_o !== '0) begin
         fails++; $display("FAIL gate_idle_data: got win=%h din=%h, expected 0", mac_win_o, mac_din_o);
      end
      wait_done(TMO + 40, seen);
      tests++;
      if (!seen || done_cyc_last != t + K + 1 + TMO) begin
         fails++; $display("FAIL timeout_done_cycle: got %0d, expected %0d", done_cyc_last, t + K + 1 + TMO);
      end
      tests++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
         fails++; $display("FAIL timeout_err: got err=%b busy=%b, expected err=1 busy=0", err_o, busy_o);
      end
      tests++;
      if (res_q.size() != r0 || pair_q.size() - p0 != K) begin
         fails++; $display("FAIL timeout_res: got res=%0d mac=%0d, expected res=0 mac=%0d", res_q.size() - r0, pair_q.size() - p0, K);
      end
      mac_silent = 1'b0;
      w0 = w_addr_q.size();
      start_job(10'h0AA, 10'h155, 8'd0, t2);
      tests++;
      if (done_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
         fails++; $display("FAIL zero_job: got done=%b err=%b busy=%b, expected done=1 err=0 busy=0", done_o, err_o, busy_o);
      end
      @(posedge clk_i); #1;
      tests++;
      if (done_o !== 1'b0 || w_addr_q.size() != w0) begin
         fails++; $display("FAIL zero_job_after: got done=%b reads=%0d, expected done=0 reads=0", done_o, w_addr_q.size() - w0);
      end
   endtask

   task automatic test_abort();
      int t, w0, p0, r0, dn0;
      mac_silent = 1'b0; mac_const_en = 1'b0;
      w0 = w_addr_q.size(); p0 = pair_q.size(); r0 = res_q.size(); dn0 = done_cnt;
      start_job(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)), 8'd2, t);
      repeat (4) @(posedge clk_i);
      #1;
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      tests++;
      if (busy_o !== 1'b0 || w_re_o !== 1'b0) begin
         fails++; $display("FAIL abort_busy: got busy=%b re=%b, expected 0", busy_o, w_re_o);
      end
      repeat (20) @(posedge clk_i);
      #1;
      tests++;
      if (w_addr_q.size() - w0 != 5 || pair_q.size() - p0 != 4) begin
         fails++; $display("FAIL abort_counts: got reads=%0d mac=%0d, expected reads=5 mac=4", w_addr_q.size() - w0, pair_q.size() - p0);
      end
      tests++;
      if (done_cnt != dn0 || res_q.size() != r0 || err_o !== 1'b0) begin
         fails++; $display("FAIL abort_quiet: got done=%0d res=%0d err=%b, expected 0 0 0", done_cnt - dn0, res_q.size() - r0, err_o);
      end
   endtask

   task automatic test_start_ignored();
      int t, w0, d0, r0, dn0;
      bit seen;
      logic [AW-1:0] wb, db;
      wb = AW'($urandom_range(0, DEPTH - 1)); db = AW'($urandom_range(0, DEPTH - 1));
      mac_lat = $urandom_range(0, 12);
      w0 = w_addr_q.size(); d0 = d_addr_q.size(); r0 = res_q.size(); dn0 = done_cnt;
      start_job(wb, db, 8'd1, t);
      @(posedge clk_i); #1;
      start_i = 1'b1; w_base_i = ~wb; d_base_i = ~db; n_out_i = 8'd5;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      wait_done(200, seen);
      tests++;
      if (!seen || w_addr_q.size() - w0 != K || d_addr_q.size() - d0 != K) begin
         fails++; $display("FAIL ignore_counts: got done=%b reads=%0d, expected done=1 reads=%0d", seen, w_addr_q.size() - w0, K);
      end else begin
         for (int k = 0; k < K; k++) begin
            tests++;
            if (w_addr_q[w0+k] !== w_exp(wb, k) || d_addr_q[d0+k] !== d_exp(db, 0, k)) begin
               fails++; $display("FAIL ignore_addr[%0d]: got w=%h d=%h, expected w=%h d=%h", k,
                                 w_addr_q[w0+k], d_addr_q[d0+k], w_exp(wb, k), d_exp(db, 0, k));
            end
         end
      end
      tests++;
      if (res_q.size() - r0 != 1 || done_cnt - dn0 != 1) begin
         fails++; $display("FAIL ignore_results: got res=%0d done=%0d, expected 1 1", res_q.size() - r0, done_cnt - dn0);
      end else begin
         tests++;
         if (res_q[r0] !== {NW'(0), exp_res(wb, db, 0)}) begin
            fails++; $display("FAIL ignore_res: got %h, expected %h", res_q[r0], {NW'(0), exp_res(wb, db, 0)});
         end
      end
   endtask

   task automatic test_async_reset();
      int t, t2, d0, r0, dn0;
      bit seen;
      logic [AW-1:0] wb, db;
      mac_lat = 12; mac_const_en = 1'b0;
      start_job(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)), 8'd2, t);
      repeat (K + 3) @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      tests++;
      if ({busy_o, done_o, err_o, w_re_o, d_re_o, mac_vld_o, res_vld_o} !== 7'b0 ||
          {w_addr_o, d_addr_o, res_data_o, res_idx_o, mac_win_o, mac_din_o} !== '0) begin
         fails++; $display("FAIL async_reset_outputs: got %b/%h, expected all 0",
                           {busy_o, done_o, err_o, w_re_o, d_re_o, mac_vld_o, res_vld_o},
                           {w_addr_o, d_addr_o, res_data_o, res_idx_o, mac_win_o, mac_din_o});
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      wb = AW'($urandom_range(0, DEPTH - 1)); db = AW'($urandom_range(0, DEPTH - 1));
      mac_lat = $urandom_range(0, 12);
      d0 = d_addr_q.size(); r0 = res_q.size(); dn0 = done_cnt;
      start_job(wb, db, 8'd2, t2);
      wait_done(200, seen);
      tests++;
      if (!seen || d_addr_q.size() - d0 != 2 * K || res_q.size() - r0 != 2 || done_cnt - dn0 != 1) begin
         fails++; $display("FAIL post_reset_job: got done=%b reads=%0d res=%0d, expected 1 %0d 2",
                           seen, d_addr_q.size() - d0, res_q.size() - r0, 2 * K);
      end else begin
         for (int j = 0; j < 2; j++) begin
            tests++;
            if (res_q[r0+j] !== {NW'(j), exp_res(wb, db, j)} || d_addr_q[d0+j*K] !== d_exp(db, j, 0)) begin
               fails++; $display("FAIL post_reset_res[%0d]: got %h d=%h, expected %h d=%h", j, res_q[r0+j],
                                 d_addr_q[d0+j*K], {NW'(j), exp_res(wb, db, j)}, d_exp(db, j, 0));
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         wmem[i] = WIDTH'($urandom) | 8'h01;
         dmem[i] = WIDTH'($urandom) | 8'h01;
      end
      test_reset();
      test_single();
      test_multi_wrap();
      test_timeout();
      test_abort();
      test_start_ignored();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
